// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding.
package timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/down_counter_core.sv
// Presettable down-counter datapath: synchronous load, guarded decrement, hold,
// and terminal compares. Sequencing lives in the wrapper.
module down_counter_core #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             is_one_o,
  output logic             is_zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load beats decrement; decrement is blocked at zero so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign is_one_o  = (count_q == WIDTH'(1));
  assign is_zero_o = (count_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Presettable countdown timer: FSM, reload register and registered busy/done
// wrapped around one down_counter_core.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             input_clock1_1,
  input  logic             input_reset_n1_2,
  input  logic             input_start1_3,
  input  logic             input_stop1_4,
  input  logic             input_tick1_5,
  input  logic [WIDTH-1:0] input_load1_6,
  output logic [WIDTH-1:0] output_count1_7,
  output logic             output_busy1_8,
  output logic             output_done1_9
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, done_q;

  logic             core_load;
  logic             core_use_reload;
  logic             core_dec;
  logic [WIDTH-1:0] core_load_val;
  logic             core_is_one;
  logic             core_is_zero;
  logic             load_is_zero;

  assign load_is_zero  = (input_load1_6 == '0);
  assign core_load_val = core_use_reload ? reload_q : input_load1_6;

  // Next-state decode. In RUN and DONE: stop > start > tick/reload.
  // In IDLE stop has no meaning, so a simultaneous start is still accepted.
  always_comb begin
    state_d         = state_q;
    reload_d        = reload_q;
    core_load       = 1'b0;
    core_use_reload = 1'b0;
    core_dec        = 1'b0;
    case (state_q)
      IDLE: begin
        if (input_start1_3) begin
          core_load = 1'b1;
          reload_d  = input_load1_6;
          state_d   = load_is_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (input_stop1_4) begin
          state_d = IDLE;
        end else if (input_start1_3) begin
          core_load = 1'b1;
          reload_d  = input_load1_6;
          state_d   = load_is_zero ? DONE : RUN;
        end else if (input_tick1_5 && !core_is_zero) begin
          core_dec = 1'b1;
          if (core_is_one) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (input_stop1_4) begin
          state_d = IDLE;
        end else if (input_start1_3) begin
          core_load = 1'b1;
          reload_d  = input_load1_6;
          state_d   = load_is_zero ? DONE : RUN;
        end else if (AUTO_RELOAD && (reload_q != '0)) begin
          core_load       = 1'b1;
          core_use_reload = 1'b1;
          state_d         = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge input_clock1_1 or negedge input_reset_n1_2) begin
    if (!input_reset_n1_2) begin
      state_q  <= IDLE;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  down_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i      (input_clock1_1),
    .rst_ni     (input_reset_n1_2),
    .load_i     (core_load),
    .load_val_i (core_load_val),
    .dec_i      (core_dec),
    .count_o    (output_count1_7),
    .is_one_o   (core_is_one),
    .is_zero_o  (core_is_zero)
  );

  assign output_busy1_8 = busy_q;
  assign output_done1_9 = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one instance without and one with auto-reload,
// driven from shared inputs and checked against hand-derived expectations.
module tb_countdown_timer;

  localparam int W  = 3;
  localparam int EW = W + 2;

  typedef struct {
    logic         start;
    logic         stop;
    logic         tick;
    logic [W-1:0] load;
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         tick;
  logic [W-1:0] load;
  logic [W-1:0] cnt0, cnt1;
  logic         busy0, busy1;
  logic         done0, done1;

  logic [EW-1:0] exp_q[$];
  int checks;
  int errors;
  vec_t vecs[36];

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
    .input_clock1_1   (clk),
    .input_reset_n1_2 (rst_n),
    .input_start1_3   (start),
    .input_stop1_4    (stop),
    .input_tick1_5    (tick),
    .input_load1_6    (load),
    .output_count1_7  (cnt0),
    .output_busy1_8   (busy0),
    .output_done1_9   (done0)
  );

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
    .input_clock1_1   (clk),
    .input_reset_n1_2 (rst_n),
    .input_start1_3   (start),
    .input_stop1_4    (stop),
    .input_tick1_5    (tick),
    .input_load1_6    (load),
    .output_count1_7  (cnt1),
    .output_busy1_8   (busy1),
    .output_done1_9   (done1)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic s, input logic p, input logic t,
                              input logic [W-1:0] ld, input logic [W-1:0] c,
                              input logic b, input logic d);
    vec_t v;
    v.start = s; v.stop = p; v.tick = t; v.load = ld;
    v.cnt = c; v.busy = b; v.done = d;
    return v;
  endfunction

  task automatic compare(input string name, input int id, input logic [EW-1:0] got,
                         input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got cnt=%0d busy=%0b done=%0b, exp cnt=%0d busy=%0b done=%0b",
               name, id, got[EW-1:2], got[1], got[0], exp[EW-1:2], exp[1], exp[0]);
    end
  endtask

  // Driver: apply inputs for one cycle, queue the expected post-edge outputs,
  // then pop and compare against the selected instance after the edge.
  task automatic step(input string name, input int id, input bit sel,
                      input logic s, input logic p, input logic t, input logic [W-1:0] ld,
                      input logic [W-1:0] ec, input logic eb, input logic ed);
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    start = s; stop = p; tick = t; load = ld;
    exp_q.push_back({ec, eb, ed});
    @(posedge clk);
    #1;
    got = sel ? {cnt1, busy1, done1} : {cnt0, busy0, done0};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s[%0d] scoreboard queue empty", name, id);
    end else begin
      exp = exp_q.pop_front();
      compare(name, id, got, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; tick = 1'b0; load = '0;

    //               start stop tick load  cnt busy done
    vecs[0]  = mk(1, 0, 1, 3'd5, 3'd5, 1, 0);   // basic count from 5
    vecs[1]  = mk(0, 0, 1, 3'd0, 3'd4, 1, 0);
    vecs[2]  = mk(0, 0, 1, 3'd0, 3'd3, 1, 0);
    vecs[3]  = mk(0, 0, 1, 3'd0, 3'd2, 1, 0);
    vecs[4]  = mk(0, 0, 1, 3'd0, 3'd1, 1, 0);
    vecs[5]  = mk(0, 0, 1, 3'd0, 3'd0, 0, 1);
    vecs[6]  = mk(0, 0, 1, 3'd0, 3'd0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 3'd3, 3'd3, 1, 0);   // gated ticks 1,0,0,1,0,1
    vecs[8]  = mk(0, 0, 1, 3'd0, 3'd2, 1, 0);
    vecs[9]  = mk(0, 0, 0, 3'd0, 3'd2, 1, 0);
    vecs[10] = mk(0, 0, 0, 3'd0, 3'd2, 1, 0);
    vecs[11] = mk(0, 0, 1, 3'd0, 3'd1, 1, 0);
    vecs[12] = mk(0, 0, 0, 3'd0, 3'd1, 1, 0);
    vecs[13] = mk(0, 0, 1, 3'd0, 3'd0, 0, 1);
    vecs[14] = mk(0, 0, 0, 3'd0, 3'd0, 0, 0);
    vecs[15] = mk(1, 0, 0, 3'd7, 3'd7, 1, 0);   // abort with stop+start
    vecs[16] = mk(0, 0, 1, 3'd0, 3'd6, 1, 0);
    vecs[17] = mk(0, 0, 1, 3'd0, 3'd5, 1, 0);
    vecs[18] = mk(1, 1, 1, 3'd7, 3'd5, 0, 0);
    vecs[19] = mk(0, 0, 1, 3'd0, 3'd5, 0, 0);
    vecs[20] = mk(1, 0, 1, 3'd2, 3'd2, 1, 0);
    vecs[21] = mk(0, 0, 1, 3'd0, 3'd1, 1, 0);
    vecs[22] = mk(0, 0, 1, 3'd0, 3'd0, 0, 1);
    vecs[23] = mk(0, 0, 0, 3'd0, 3'd0, 0, 0);
    vecs[24] = mk(1, 0, 1, 3'd0, 3'd0, 0, 1);   // zero load: done, never busy
    vecs[25] = mk(0, 0, 1, 3'd0, 3'd0, 0, 0);
    vecs[26] = mk(1, 0, 0, 3'd4, 3'd4, 1, 0);   // restart priorities
    vecs[27] = mk(0, 0, 1, 3'd0, 3'd3, 1, 0);
    vecs[28] = mk(1, 0, 1, 3'd6, 3'd6, 1, 0);
    vecs[29] = mk(1, 0, 1, 3'd0, 3'd0, 0, 1);
    vecs[30] = mk(1, 0, 0, 3'd3, 3'd3, 1, 0);
    vecs[31] = mk(1, 1, 0, 3'd5, 3'd3, 0, 0);
    vecs[32] = mk(1, 1, 0, 3'd1, 3'd1, 1, 0);
    vecs[33] = mk(0, 0, 1, 3'd0, 3'd0, 0, 1);
    vecs[34] = mk(0, 1, 1, 3'd0, 3'd0, 0, 0);
    vecs[35] = mk(0, 0, 0, 3'd0, 3'd0, 0, 0);

    // Reset state
    #12;
    compare("reset0", 0, {cnt0, busy0, done0}, '0);
    compare("reset1", 0, {cnt1, busy1, done1}, '0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step("vec", i, 1'b0, vecs[i].start, vecs[i].stop, vecs[i].tick, vecs[i].load,
           vecs[i].cnt, vecs[i].busy, vecs[i].done);
    end

    // Max load: seven decrements to zero, no wrap
    step("max", 0, 1'b0, 1, 0, 1, 3'd7, 3'd7, 1, 0);
    for (int k = 1; k <= 7; k++) begin
      step("max", k, 1'b0, 0, 0, 1, 3'd0, W'(7 - k), (k < 7), (k == 7));
    end
    step("max", 8, 1'b0, 0, 0, 1, 3'd0, 3'd0, 0, 0);

    // Asynchronous reset in the middle of a run
    step("rstrun", 0, 1'b0, 1, 0, 1, 3'd5, 3'd5, 1, 0);
    step("rstrun", 1, 1'b0, 0, 0, 1, 3'd0, 3'd4, 1, 0);
    step("rstrun", 2, 1'b0, 0, 0, 1, 3'd0, 3'd3, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    compare("rstasync0", 0, {cnt0, busy0, done0}, '0);
    compare("rstasync1", 0, {cnt1, busy1, done1}, '0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step("rstafter", k, 1'b0, 0, 0, 1, 3'd0, 3'd0, 0, 0);
    end

    // Auto-reload instance: 2,1,0 repeating, then stop in DONE
    for (int i = 0; i < 9; i++) begin
      step("autorl", i, 1'b1, (i == 0), 0, 1, 3'd2, W'(2 - (i % 3)), ((i % 3) != 2),
           ((i % 3) == 2));
    end
    step("autorl", 9, 1'b1, 0, 1, 1, 3'd2, 3'd0, 0, 0);
    step("autorl", 10, 1'b1, 0, 0, 1, 3'd2, 3'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
